// File: rtl/cmp_serial_driver.sv
// Bit-serial operand driver for the serial magnitude comparator: loads two words,
// clears the comparator, shifts both MSB-first and captures the eq/gt/lt verdict.
//
// state | meaning
// IDLE  | ready for a new request; ready=1
// CLEAR | comparator held in clear for one cycle
// SHIFT | one operand bit pair per cycle, MSB first, WIDTH cycles
// DONE  | res_valid pulse, captured verdict on res_*
module cmp_serial_driver #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_word,
  input  logic [WIDTH-1:0] b_word,
  output logic             ready,
  output logic             cmp_clear_n,
  output logic             a_bit,
  output logic             b_bit,
  output logic             bit_valid,
  input  logic             eq_in,
  input  logic             gt_in,
  input  logic             lt_in,
  output logic             res_valid,
  output logic             res_eq,
  output logic             res_gt,
  output logic             res_lt,
  output logic             res_err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

  state_t         state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CW-1:0]    cnt;
  logic             clear_n_q;
  logic [1:0]       hot_cnt;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CLEAR;
      CLEAR:   state_nxt = SHIFT;
      SHIFT:   if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign hot_cnt = 2'(eq_in) + 2'(gt_in) + 2'(lt_in);

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh    <= '0;
      b_sh    <= '0;
      cnt     <= '0;
      res_eq  <= 1'b0;
      res_gt  <= 1'b0;
      res_lt  <= 1'b0;
      res_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a_word;
            b_sh <= b_word;
            cnt  <= CW'(WIDTH - 1);
          end
        end
        SHIFT: begin
          a_sh <= a_sh << 1;
          b_sh <= b_sh << 1;
          cnt  <= cnt - 1'b1;
          if (cnt == '0) begin
            res_eq  <= eq_in;
            res_gt  <= gt_in;
            res_lt  <= lt_in;
            res_err <= (hot_cnt != 2'd1);
          end
        end
        default: ;
      endcase
    end
  end

  // Registered so the comparator's async clear never sees a decode glitch.
  always_ff @(posedge clk) begin
    if (reset) clear_n_q <= 1'b0;
    else       clear_n_q <= (state_nxt != CLEAR);
  end

  assign cmp_clear_n = clear_n_q;
  assign ready       = (state == IDLE);
  assign bit_valid   = (state == SHIFT);
  assign res_valid   = (state == DONE);
  assign a_bit       = bit_valid & a_sh[WIDTH-1];
  assign b_bit       = bit_valid & b_sh[WIDTH-1];

endmodule

// File: tb/tb_cmp_serial_driver.sv
// Self-checking bench for cmp_serial_driver: 8-bit and 1-bit instances, each
// wired to a behavioural serial comparator; results checked against integer compare.
module tb_cmp_serial_driver;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int rv_count = 0;
  bit stub_err = 1'b0;

  // 8-bit instance
  logic       start;
  logic [7:0] a_word, b_word;
  logic       ready, cmp_clear_n, a_bit, b_bit, bit_valid;
  logic       eq_in, gt_in, lt_in;
  logic       res_valid, res_eq, res_gt, res_lt, res_err;

  cmp_serial_driver #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .a_word(a_word), .b_word(b_word),
    .ready(ready), .cmp_clear_n(cmp_clear_n), .a_bit(a_bit), .b_bit(b_bit),
    .bit_valid(bit_valid), .eq_in(eq_in), .gt_in(gt_in), .lt_in(lt_in),
    .res_valid(res_valid), .res_eq(res_eq), .res_gt(res_gt), .res_lt(res_lt),
    .res_err(res_err)
  );

  // 1-bit instance
  logic       s1_start;
  logic [0:0] s1_a, s1_b;
  logic       s1_ready, s1_clr_n, s1_a_bit, s1_b_bit, s1_bv;
  logic       s1_eq, s1_gt, s1_lt;
  logic       s1_rv, s1_req, s1_rgt, s1_rlt, s1_rerr;

  cmp_serial_driver #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .start(s1_start), .a_word(s1_a), .b_word(s1_b),
    .ready(s1_ready), .cmp_clear_n(s1_clr_n), .a_bit(s1_a_bit), .b_bit(s1_b_bit),
    .bit_valid(s1_bv), .eq_in(s1_eq), .gt_in(s1_gt), .lt_in(s1_lt),
    .res_valid(s1_rv), .res_eq(s1_req), .res_gt(s1_rgt), .res_lt(s1_rlt),
    .res_err(s1_rerr)
  );

  // Serial comparator model: 0=equal so far, 1=A greater, 2=A less; first differing pair decides.
  logic [1:0] c8, c1;
  always @(posedge clk or negedge cmp_clear_n)
    if (!cmp_clear_n) c8 <= 2'd0;
    else if (bit_valid && c8 == 2'd0) c8 <= (a_bit & ~b_bit) ? 2'd1 : (~a_bit & b_bit) ? 2'd2 : 2'd0;
  assign eq_in = stub_err ? 1'b0 : (c8 == 2'd0) && !(bit_valid && (a_bit != b_bit));
  assign gt_in = stub_err ? 1'b1 : (c8 == 2'd1) || ((c8 == 2'd0) && bit_valid && a_bit && !b_bit);
  assign lt_in = stub_err ? 1'b1 : (c8 == 2'd2) || ((c8 == 2'd0) && bit_valid && !a_bit && b_bit);

  always @(posedge clk or negedge s1_clr_n)
    if (!s1_clr_n) c1 <= 2'd0;
    else if (s1_bv && c1 == 2'd0) c1 <= (s1_a_bit & ~s1_b_bit) ? 2'd1 : (~s1_a_bit & s1_b_bit) ? 2'd2 : 2'd0;
  assign s1_eq = (c1 == 2'd0) && !(s1_bv && (s1_a_bit != s1_b_bit));
  assign s1_gt = (c1 == 2'd1) || ((c1 == 2'd0) && s1_bv && s1_a_bit && !s1_b_bit);
  assign s1_lt = (c1 == 2'd2) || ((c1 == 2'd0) && s1_bv && !s1_a_bit && s1_b_bit);

  always @(negedge clk) if (res_valid === 1'b1) rv_count++;

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input bit busy, input bit stub);
    logic [3:0] exp_r;
    int rv0;
    if (stub) exp_r = 4'b0111;
    else      exp_r = {a == b, a > b, a < b, 1'b0};
    stub_err = stub;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL ready_before_start got=%b exp=1", ready); end
    start = 1'b1; a_word = a; b_word = b; rv0 = rv_count;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if ({cmp_clear_n, ready, bit_valid, a_bit, b_bit} !== 5'b00000) begin
      errors++; $display("FAIL clear_cycle clr_n/ready/bv/a/b got=%b exp=00000",
                         {cmp_clear_n, ready, bit_valid, a_bit, b_bit});
    end
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      checks++;
      if ({bit_valid, a_bit, b_bit, cmp_clear_n, res_valid, ready} !== {1'b1, a[7-k], b[7-k], 3'b100}) begin
        errors++; $display("FAIL shift_bit%0d bv/a/b/clr_n/rv/ready got=%b exp=%b", k,
                           {bit_valid, a_bit, b_bit, cmp_clear_n, res_valid, ready},
                           {1'b1, a[7-k], b[7-k], 3'b100});
      end
      if (busy && k == 2) begin start = 1'b1; a_word = ~a; b_word = b ^ 8'h5a; end
      if (busy && k == 4) start = 1'b0;
    end
    @(posedge clk); #1;
    checks++;
    if ({res_valid, bit_valid, ready} !== 3'b100) begin
      errors++; $display("FAIL done_cycle rv/bv/ready got=%b exp=100", {res_valid, bit_valid, ready});
    end
    checks++;
    if ({res_eq, res_gt, res_lt, res_err} !== exp_r) begin
      errors++; $display("FAIL result a=%h b=%h eq/gt/lt/err got=%b exp=%b", a, b,
                         {res_eq, res_gt, res_lt, res_err}, exp_r);
    end
    @(posedge clk); #1;
    checks++;
    if ({ready, res_valid, bit_valid} !== 3'b100) begin
      errors++; $display("FAIL ready_return ready/rv/bv got=%b exp=100", {ready, res_valid, bit_valid});
    end
    checks++;
    if ({res_eq, res_gt, res_lt, res_err} !== exp_r) begin
      errors++; $display("FAIL result_hold got=%b exp=%b", {res_eq, res_gt, res_lt, res_err}, exp_r);
    end
    checks++;
    if (rv_count - rv0 != 1) begin
      errors++; $display("FAIL res_valid_count got=%0d exp=1", rv_count - rv0);
    end
    stub_err = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ready, bit_valid, a_bit, b_bit, res_valid, cmp_clear_n} !== 6'b100000) begin
      errors++; $display("FAIL reset_ctrl ready/bv/a/b/rv/clr_n got=%b exp=100000",
                         {ready, bit_valid, a_bit, b_bit, res_valid, cmp_clear_n});
    end
    checks++;
    if ({res_eq, res_gt, res_lt, res_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_res got=%b exp=0000", {res_eq, res_gt, res_lt, res_err});
    end
    checks++;
    if ({s1_ready, s1_bv, s1_rv, s1_clr_n} !== 4'b1000) begin
      errors++; $display("FAIL reset_w1 ready/bv/rv/clr_n got=%b exp=1000", {s1_ready, s1_bv, s1_rv, s1_clr_n});
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({cmp_clear_n, ready} !== 2'b11) begin
      errors++; $display("FAIL post_reset clr_n/ready got=%b exp=11", {cmp_clear_n, ready});
    end
  endtask

  task automatic test_equal();       do_op(8'hA5, 8'hA5, 1'b0, 1'b0); endtask
  task automatic test_msb();         do_op(8'h80, 8'h7F, 1'b0, 1'b0); endtask
  task automatic test_back_to_back(); do_op(8'h12, 8'h13, 1'b0, 1'b0); do_op(8'h13, 8'h12, 1'b0, 1'b0); endtask
  task automatic test_busy();        do_op(8'h3C, 8'hC3, 1'b1, 1'b0); endtask
  task automatic test_err();         do_op(8'h55, 8'h55, 1'b0, 1'b1); do_op(8'h55, 8'h55, 1'b0, 1'b0); endtask

  task automatic test_random();
    logic [7:0] a, b;
    for (int i = 0; i < 10; i++) begin
      a = 8'($urandom);
      b = (i % 3 == 0) ? a : ((i % 3 == 1) ? a ^ (8'd1 << $urandom_range(7, 0)) : 8'($urandom));
      do_op(a, b, (i % 4 == 3), 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    int rv0;
    rv0 = rv_count;
    start = 1'b1; a_word = 8'hF0; b_word = 8'h0F;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (bit_valid !== 1'b1) begin errors++; $display("FAIL mid_shift_bv got=%b exp=1", bit_valid); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({ready, bit_valid, res_valid, cmp_clear_n, a_bit, b_bit} !== 6'b100000) begin
      errors++; $display("FAIL mid_reset_ctrl ready/bv/rv/clr_n/a/b got=%b exp=100000",
                         {ready, bit_valid, res_valid, cmp_clear_n, a_bit, b_bit});
    end
    checks++;
    if ({res_eq, res_gt, res_lt, res_err} !== 4'b0000) begin
      errors++; $display("FAIL mid_reset_res got=%b exp=0000", {res_eq, res_gt, res_lt, res_err});
    end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rv_count != rv0) begin errors++; $display("FAIL mid_reset_no_valid got=%0d exp=%0d", rv_count, rv0); end
    do_op(8'hF0, 8'h0F, 1'b0, 1'b0);
  endtask

  task automatic test_min_width();
    s1_start = 1'b1; s1_a = 1'b1; s1_b = 1'b0;
    @(posedge clk); #1;
    s1_start = 1'b0;
    checks++;
    if ({s1_clr_n, s1_ready, s1_bv} !== 3'b000) begin
      errors++; $display("FAIL w1_clear clr_n/ready/bv got=%b exp=000", {s1_clr_n, s1_ready, s1_bv});
    end
    @(posedge clk); #1;
    checks++;
    if ({s1_bv, s1_a_bit, s1_b_bit, s1_rv} !== 4'b1100) begin
      errors++; $display("FAIL w1_shift bv/a/b/rv got=%b exp=1100", {s1_bv, s1_a_bit, s1_b_bit, s1_rv});
    end
    @(posedge clk); #1;
    checks++;
    if ({s1_rv, s1_bv, s1_req, s1_rgt, s1_rlt, s1_rerr} !== 6'b100100) begin
      errors++; $display("FAIL w1_result rv/bv/eq/gt/lt/err got=%b exp=100100",
                         {s1_rv, s1_bv, s1_req, s1_rgt, s1_rlt, s1_rerr});
    end
    @(posedge clk); #1;
    checks++;
    if ({s1_ready, s1_rv} !== 2'b10) begin
      errors++; $display("FAIL w1_ready ready/rv got=%b exp=10", {s1_ready, s1_rv});
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; a_word = '0; b_word = '0;
    s1_start = 1'b0; s1_a = '0; s1_b = '0;
    test_reset();
    test_equal();
    test_msb();
    test_back_to_back();
    test_busy();
    test_random();
    test_reset_mid();
    test_err();
    test_min_width();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
